// File: rtl/mbisr_pkg.sv
// Shared types, default sizes and the first-free priority encoder for the MBISR repair map.
package mbisr_pkg;

    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_NUM_SPARES = 4;
    localparam int unsigned DEF_IDX_W      = 3;
    localparam int unsigned MAX_SPARES     = 8;
    localparam int unsigned SEL_W          = 3;
    localparam int unsigned FCNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } free_sel_t;

    // Lowest-index clear bit of the occupancy mask; unpopulated slots are passed in as 1.
    function automatic free_sel_t first_free(input logic [MAX_SPARES-1:0] used);
        free_sel_t sel;
        sel = '0;
        for (int i = MAX_SPARES - 1; i >= 0; i--) begin
            if (!used[i]) begin
                sel.found = 1'b1;
                sel.idx   = SEL_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mbisr_repair_map_if.sv
// Fail-report and remap-lookup bus between MBIST / memory wrapper and the repair map.
interface mbisr_repair_map_if
    import mbisr_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
) ();

    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic              fail_ready;
    logic              acc_en;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_hit;
    logic [IDX_W-1:0]  acc_idx;

    modport slave (
        input  fail_valid, fail_addr, acc_en, acc_addr,
        output fail_ready, acc_hit, acc_idx
    );

    modport master (
        output fail_valid, fail_addr, acc_en, acc_addr,
        input  fail_ready, acc_hit, acc_idx
    );

endinterface

// File: rtl/mbisr_spare_entry.sv
// One spare-word CAM entry: valid bit plus stored address, with match against fail and lookup buses.
module mbisr_spare_entry
    import mbisr_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic              valid,
    output logic              fail_match_c,
    output logic              acc_match_c
);

    logic [ADDR_W-1:0] addr_q;

    // Clear wins over write so a new session never inherits an old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            addr_q <= '0;
        end else if (clr) begin
            valid  <= 1'b0;
        end else if (wr) begin
            valid  <= 1'b1;
            addr_q <= fail_addr;
        end
    end

    assign fail_match_c = valid & (addr_q == fail_addr);
    assign acc_match_c  = valid & (addr_q == acc_addr);

endmodule

// File: rtl/mbisr_repair_map.sv
// Spare-word repair allocator and remap lookup behind the MBIST engine.
// Optional saturating fail-report counter built only when MBISR_FAIL_CNT_EN is defined.
module mbisr_repair_map
    import mbisr_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_SPARES = DEF_NUM_SPARES,
    parameter int unsigned IDX_W      = DEF_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    bist_done,
    mbisr_repair_map_if.slave       bus,
    output logic [IDX_W:0]          used_count,
    output logic                    locked,
    output logic                    repair_ok,
    output logic                    unrepairable,
    output logic [FCNT_W-1:0]       fail_count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    state_e                  state_q;
    state_e                  state_d;
    logic                    clr_all;
    logic                    close_sess;

    logic [NUM_SPARES-1:0]   valid_vec;
    logic [NUM_SPARES-1:0]   fail_match;
    logic [NUM_SPARES-1:0]   acc_match;
    logic [NUM_SPARES-1:0]   wr_vec;
    logic [MAX_SPARES-1:0]   used_pad;
    free_sel_t               free_sel;

    logic                    fail_ready_q;
    logic                    accept;
    logic                    fail_hit;
    logic                    alloc;
    logic                    overflow;
    logic                    unrep_d;

    logic                    acc_hit_d;
    logic [IDX_W-1:0]        acc_idx_d;
    logic                    acc_hit_q;
    logic [IDX_W-1:0]        acc_idx_q;

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start restarts from any state and takes priority over bist_done.
    always_comb begin
        state_d    = state_q;
        clr_all    = 1'b0;
        close_sess = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    clr_all = 1'b1;
                end
            end
            COLLECT: begin
                if (start) begin
                    clr_all = 1'b1;
                end else if (bist_done) begin
                    state_d    = LOCKED;
                    close_sess = 1'b1;
                end
            end
            LOCKED: begin
                if (start) begin
                    state_d = COLLECT;
                    clr_all = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Allocation decision for the current fail report.
    always_comb begin
        used_pad                   = '1;
        used_pad[NUM_SPARES-1:0]   = valid_vec;
        free_sel                   = first_free(used_pad);
        accept                     = bus.fail_valid & fail_ready_q & ~clr_all;
        fail_hit                   = |fail_match;
        alloc                      = accept & ~fail_hit & free_sel.found;
        overflow                   = accept & ~fail_hit & ~free_sel.found;
        unrep_d                    = unrepairable | overflow;
    end

    for (genvar gi = 0; gi < NUM_SPARES; gi++) begin : g_entry
        assign wr_vec[gi] = alloc & (free_sel.idx == SEL_W'(gi));

        mbisr_spare_entry #(
            .ADDR_W (ADDR_W)
        ) u_entry (
            .clk          (clk),
            .rst_n        (rst_n),
            .clr          (clr_all),
            .wr           (wr_vec[gi]),
            .fail_addr    (bus.fail_addr),
            .acc_addr     (bus.acc_addr),
            .valid        (valid_vec[gi]),
            .fail_match_c (fail_match[gi]),
            .acc_match_c  (acc_match[gi])
        );
    end

    // Status flags; repair_ok sees a fail accepted on the closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_ready_q <= 1'b0;
            locked       <= 1'b0;
            used_count   <= '0;
            unrepairable <= 1'b0;
            repair_ok    <= 1'b0;
        end else begin
            fail_ready_q <= (state_d == COLLECT);
            locked       <= (state_d == LOCKED);
            if (clr_all) begin
                used_count   <= '0;
                unrepairable <= 1'b0;
                repair_ok    <= 1'b0;
            end else begin
                if (alloc) begin
                    used_count <= used_count + CNT_W'(1);
                end
                if (overflow) begin
                    unrepairable <= 1'b1;
                end
                if (close_sess) begin
                    repair_ok <= ~unrep_d;
                end
            end
        end
    end

    // Lookup encoder; the table never holds duplicates so at most one bit is set.
    always_comb begin
        acc_hit_d = |acc_match;
        acc_idx_d = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (acc_match[i]) begin
                acc_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit_q <= 1'b0;
            acc_idx_q <= '0;
        end else begin
            acc_hit_q <= bus.acc_en & acc_hit_d;
            acc_idx_q <= bus.acc_en ? acc_idx_d : '0;
        end
    end

    assign bus.fail_ready = fail_ready_q;
    assign bus.acc_hit    = acc_hit_q;
    assign bus.acc_idx    = acc_idx_q;

`ifdef MBISR_FAIL_CNT_EN
    // Saturating count of every accepted report, duplicates and overflow included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count <= '0;
        end else if (clr_all) begin
            fail_count <= '0;
        end else if (accept && (fail_count != '1)) begin
            fail_count <= fail_count + FCNT_W'(1);
        end
    end
`else
    assign fail_count = '0;
`endif

endmodule

// File: doc/mbisr_repair_map.md
Name: mbisr_repair_map

Overview:
- Repair-allocation stage directly downstream of the MBIST March engine.
- Consumes fail addresses reported during a BIST session and allocates them to a small pool of spare words, deduplicating repeat reports.
- After the session, serves address-remap lookups to the memory wrapper: hit plus spare index.
- Reports repair success or unrepairable status to the top level; the top drives uo_out[1] from the unrepairable flag.

Parameters:
- ADDR_W, 5, width of the memory word address.
- NUM_SPARES, 4, number of spare words (CAM entries), 1..8.
- IDX_W, 3, width of the spare index; must satisfy 2**IDX_W >= NUM_SPARES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; opens a new collection session and clears the table.
- fail_valid  in  1  MBIST reports a failing address.
- fail_addr  in  ADDR_W  failing address; qualified by fail_valid.
- fail_ready  out  1  high while in COLLECT.
- bist_done  in  1  one-cycle pulse from MBIST at end of March; closes the session.
- acc_en  in  1  lookup request.
- acc_addr  in  ADDR_W  lookup address.
- acc_hit  out  1  registered; acc_addr mapped to a spare.
- acc_idx  out  IDX_W  registered spare index; 0 when acc_hit=0.
- used_count  out  IDX_W+1  number of allocated spares.
- locked  out  1  high in LOCKED state.
- repair_ok  out  1  valid when locked; all fails repaired.
- unrepairable  out  1  sticky; a distinct fail address found no free spare.
- fail_count  out  8  saturating count of accepted fail reports (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all entries invalid.
  - All outputs 0: fail_ready, acc_hit, acc_idx, used_count, locked, repair_ok, unrepairable, fail_count.
- FSM states: IDLE, COLLECT, LOCKED.
  - IDLE: start -> COLLECT.
  - COLLECT: bist_done -> LOCKED; start -> COLLECT (restart).
  - LOCKED: start -> COLLECT.
- Entering COLLECT (start):
  - Invalidate all entries; clear used_count, unrepairable, repair_ok, locked, fail_count.
  - A fail_valid in the same cycle as start is not accepted (fail_ready is still 0).
- Accept condition: fail_valid & fail_ready. Action on accept, in priority order:
  - fail_addr matches a valid entry -> no allocation.
  - Else a free entry exists -> write the lowest-index free entry; used_count += 1.
  - Else -> set unrepairable; the table is unchanged.
- Table updates take effect at the accepting edge. A match check in the next cycle sees the new entry, so back-to-back duplicates allocate only once.
- bist_done and an accepted fail in the same cycle: the fail is processed first. repair_ok is then set at that edge to !(unrepairable_next).
- bist_done in IDLE or LOCKED: ignored.
- Lookup (active in all states), latency 1:
  - At each edge with acc_en=1: acc_hit <= match among entries as they stood before that edge; acc_idx <= matching index.
  - With acc_en=0, acc_hit <= 0 and acc_idx <= 0.
- The table never stores duplicate addresses, so at most one entry matches.
- used_count saturates at NUM_SPARES by construction.
- Reset mid-session: immediate return to the reset values above. No partial repair survives reset.

Optional Feature:
- Macro: MBISR_FAIL_CNT_EN.
- Defined: fail_count increments on every accepted fail (duplicates and overflow included), saturates at 255, and clears on start.
- Undefined: fail_count is tied to 0 and no counter flops are built.

Decomposition:
- mbisr_pkg:
  - state enum (IDLE/COLLECT/LOCKED).
  - default ADDR_W and NUM_SPARES constants.
  - helper function for first-free index (priority encoder).
- Sub-module mbisr_spare_entry: one CAM entry.
  - Holds the valid bit and stored address; supports clear and write.
  - Outputs two combinational match bits, one for fail_addr and one for acc_addr.
- The top instantiates NUM_SPARES entries via generate.

Test Plan:
- Reset, start, 3 fails 0x03, 0x11, 0x03, then bist_done -> used_count=2, repair_ok=1, unrepairable=0, locked=1.
- start, 5 distinct fails 0x01..0x05 with NUM_SPARES=4 -> used_count=4, unrepairable=1 after the 5th, repair_ok=0 after bist_done.
- After the first scenario, lookup acc_addr=0x11 -> next cycle acc_hit=1, acc_idx=1; acc_addr=0x04 -> acc_hit=0, acc_idx=0.
- fail_valid with 0x1F in the same cycle as bist_done -> entry allocated; used_count reflects it; locked=1 next cycle.
- rst_n asserted mid-COLLECT with 2 entries allocated -> all outputs 0 immediately; lookup of a prior fail address -> acc_hit=0.
- With MBISR_FAIL_CNT_EN: 300 fail reports of 0x07 -> fail_count=255, used_count=1. Without the macro: fail_count=0.
